bus_primary_engine: RTL and testbench
=====================================

// Module: bus_primary_engine
// PURPOSE
//  Synthesizable, parametrised bus primary for the multiplexed main bus (AddrValid/rw/AddrData).
//  Accepts one burst command at a time from a local requester and sequences it on the bus:
//  - one address cycle;
//  - for writes, BURST_LEN data cycles;
//  - for reads, one turnaround cycle, then BURST_LEN capture cycles.
//  Replaces hand-driven bus tasks; sits between a CPU/DMA requester and the memory controller.
// PARAMETERS
//  DATA_W     16  width of AddrData, cmd_addr, wr_data, rd_data (>=8)
//  BURST_LEN  4   beats per transaction (1..16)
//  IDLE_GAP   1   minimum idle cycles after a transaction before the next ADDR (0..15)
//  PAGE_W     4   number of top address bits compared in the address check
//  PAGE_ID    2   legal page value of cmd_addr[DATA_W-1 -: PAGE_W]
// PORTS
//  clk        in     1        bus clock; all logic on posedge
//  rst_n      in     1        asynchronous, active-low reset
//  cmd_valid  in     1        command request
//  cmd_ready  out    1        command accepted when cmd_valid & cmd_ready
//  cmd_rw     in     1        1 = read, 0 = write
//  cmd_addr   in     DATA_W   burst base address
//  wr_valid   in     1        write-beat push into the write buffer
//  wr_ready   out    1        write buffer can take a beat
//  wr_data    in     DATA_W   write beat
//  rd_valid   out    1        read beat valid; one-cycle pulse; no backpressure
//  rd_last    out    1        asserted with the final read beat
//  rd_data    out    DATA_W   captured read beat
//  cmd_err    out    1        one-cycle pulse: command rejected (only with ADDR_CHECK_EN)
//  busy       out    1        high in any state other than IDLE
//  AddrValid  out    1        bus address strobe
//  rw         out    1        bus direction: 1 = read, 0 = write
//  AddrData   inout  DATA_W   multiplexed bus; driven when AddrValid | ~rw, else 'z
// BEHAVIOUR
//  Reset (async assert, sync release): state = IDLE, wcount = 0, gap counter = 0.
//   - AddrValid = 0, rw = 1 (bus released), drive register = 0.
//   - cmd_ready = 0, wr_ready = 1, rd_valid = 0, rd_last = 0, rd_data = 0, cmd_err = 0, busy = 0.
//  Write buffer: BURST_LEN x DATA_W, counter wcount.
//   - wr_ready = (wcount < BURST_LEN) & (state != WDATA); push on wr_valid & wr_ready.
//   - A push when full is ignored.
//  cmd_ready = (state == IDLE) & gap counter == 0 & (cmd_rw | wcount == BURST_LEN).
//  States (one cycle each unless stated):
//   IDLE  -> ADDR on accept; cmd_addr and cmd_rw are registered at accept.
//   ADDR  AddrValid = 1, AddrData = addr, rw = cmd_rw. Next state: ~rw -> WDATA, rw -> TURN.
//   WDATA BURST_LEN cycles; AddrData = buf[beat], rw = 0, AddrValid = 0.
//         wcount clears to 0 on the last beat; -> GAP.
//   TURN  AddrData released ('z), rw = 1; -> RDATA.
//   RDATA BURST_LEN cycles; each posedge samples AddrData into rd_data.
//         rd_valid pulses the following cycle; rd_last accompanies beat BURST_LEN-1; -> GAP.
//   GAP   counts IDLE_GAP cycles with the bus released; -> IDLE. IDLE_GAP = 0 skips GAP entirely.
//  Beat counter: $clog2(BURST_LEN)+1 bits; compares against BURST_LEN-1; no wrap past the burst.
//  Latency:
//   - write: accept -> AddrValid next cycle; bus occupied 1+BURST_LEN cycles.
//   - read: first rd_valid 3 cycles after ADDR; 2+BURST_LEN bus cycles.
//  Bus turnaround:
//   - AddrData goes 'z on the cycle after the last WDATA beat and after ADDR of a read.
//   - The engine never drives AddrData during TURN or RDATA.
//  Write data for the next burst may be pushed during TURN, RDATA or GAP.
//  cmd_valid while busy: held off (cmd_ready = 0); no queueing.
//  Reset mid-burst: immediate return to reset values. The bus is released asynchronously.
//   Partially buffered write data is discarded.
// CONFIGURATION
//  ADDR_CHECK_EN defined:
//   - An IDLE handshake with cmd_addr page != PAGE_ID is accepted and produces a 1-cycle cmd_err.
//   - No bus activity results; for writes, wcount clears (buffer discarded).
//  ADDR_CHECK_EN undefined:
//   - Every address goes to the bus.
//   - cmd_err is tied to 0; the PAGE_W and PAGE_ID parameters are unused.
// TESTING
//  1 Reset: rst_n low mid-WDATA -> AddrValid = 0, AddrData = 'z, busy = 0, wr_ready = 1, same cycle.
//  2 Write 0x2000, beats ABCD,1234,5678,9ABC:
//    -> AddrValid one cycle with 0x2000, then those 4 beats on consecutive cycles, rw = 0.
//  3 Read 0x2000 against a memory model -> rd_valid x4 returns ABCD..9ABC.
//    rd_last only on 9ABC; no primary drive during TURN/RDATA.
//  4 Back-to-back write then read with IDLE_GAP = 2:
//    -> exactly 2 released cycles between the last WDATA beat and the next ADDR.
//  5 ADDR_CHECK_EN, write 0x5000 -> cmd_err pulse, AddrValid stays 0, wcount = 0.
//    Without the macro -> normal burst to 0x5000.
//  6 BURST_LEN = 8, DATA_W = 32: write command with only 7 beats buffered
//    -> cmd_ready = 0; 8th push -> accepted, 8 beats on bus.

Source files
------------

// File: rtl/bus_primary_engine.sv
// Burst primary for the multiplexed AddrValid/rw/AddrData bus: one address cycle, then write beats or turnaround plus read beats.
// Optional page check on command addresses is enabled by defining ADDR_CHECK_EN.
module bus_primary_engine #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int IDLE_GAP  = 1,
  parameter int PAGE_W    = 4,
  parameter int PAGE_ID   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [DATA_W-1:0] cmd_addr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              cmd_err,
  output logic              busy,
  output logic              AddrValid,
  output logic              rw,
  inout  wire  [DATA_W-1:0] AddrData
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] FULL      = BW'(BURST_LEN);
  // The IDLE cycle itself is one released cycle, so GAP covers the remainder.
  localparam logic [3:0]    GAP_LOAD  = (IDLE_GAP > 1) ? 4'(IDLE_GAP - 1) : 4'd0;

`ifdef ADDR_CHECK_EN
  localparam bit CHECK_PAGE = 1'b1;
`else
  localparam bit CHECK_PAGE = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_TURN, S_RDATA, S_GAP} state_t;

  state_t            state;
  logic [BW-1:0]     wcount;
  logic [BW-1:0]     beat;
  logic [BW-1:0]     nxt_beat;
  logic [3:0]        gap_cnt;
  logic [DATA_W-1:0] drive;
  logic              err_q;
  logic              push;
  logic              accept;
  logic              page_bad;
  logic [DATA_W-1:0] wbuf [2**IW];

  // Handshakes: a transfer happens on a rising edge with valid and ready both high;
  // ready never depends on its own valid, valid holds until taken; rd_valid has no ready.
  assign cmd_ready = (state == S_IDLE) && (gap_cnt == 4'd0) && (cmd_rw || (wcount == FULL));
  assign wr_ready  = (wcount < FULL) && (state != S_WDATA);
  assign push      = wr_valid && wr_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign cmd_err   = err_q;
  assign nxt_beat  = beat + 1'b1;
  assign page_bad  = CHECK_PAGE && (cmd_addr[DATA_W-1 -: PAGE_W] != PAGE_W'(PAGE_ID));
  assign AddrData  = (AddrValid || !rw) ? drive : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (push) wbuf[wcount[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wcount    <= '0;
      beat      <= '0;
      gap_cnt   <= '0;
      drive     <= '0;
      AddrValid <= 1'b0;
      rw        <= 1'b1;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      rd_data   <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      err_q    <= 1'b0;
      if (push) wcount <= wcount + 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (page_bad) begin
              err_q <= 1'b1;
              if (!cmd_rw) wcount <= '0;
            end else begin
              state     <= S_ADDR;
              AddrValid <= 1'b1;
              rw        <= cmd_rw;
              drive     <= cmd_addr;
            end
          end
        end
        S_ADDR: begin
          AddrValid <= 1'b0;
          beat      <= '0;
          if (rw) begin
            state <= S_TURN;
            drive <= '0;
          end else begin
            state <= S_WDATA;
            drive <= wbuf[0];
          end
        end
        S_WDATA: begin
          if (beat == LAST_BEAT) begin
            wcount <= '0;
            rw     <= 1'b1;
            drive  <= '0;
            beat   <= '0;
            if (IDLE_GAP > 1) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            beat  <= nxt_beat;
            drive <= wbuf[nxt_beat[IW-1:0]];
          end
        end
        S_TURN: begin
          state <= S_RDATA;
          beat  <= '0;
        end
        S_RDATA: begin
          rd_data  <= AddrData;
          rd_valid <= 1'b1;
          rd_last  <= (beat == LAST_BEAT);
          if (beat == LAST_BEAT) begin
            beat <= '0;
            if (IDLE_GAP > 1) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            beat <= nxt_beat;
          end
        end
        S_GAP: begin
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_primary_engine.sv
// Directed bench for bus_primary_engine: a 16-bit/4-beat engine with a memory model on its bus,
// plus a 32-bit/8-beat engine for the long-burst buffer case.
module tb_bus_primary_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0, wr_valid = 1'b0;
  logic [15:0] cmd_addr = '0, wr_data = '0;
  logic        cmd_ready, wr_ready, rd_valid, rd_last, cmd_err, busy, AddrValid, rw;
  logic [15:0] rd_data;
  wire  [15:0] AddrData;

  logic        b_cmd_valid = 1'b0, b_cmd_rw = 1'b0, b_wr_valid = 1'b0;
  logic [31:0] b_cmd_addr = '0, b_wr_data = '0;
  logic        b_cmd_ready, b_wr_ready, b_rd_valid, b_rd_last, b_cmd_err, b_busy, b_AddrValid, b_rw;
  logic [31:0] b_rd_data;
  wire  [31:0] b_AddrData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_primary_engine #(.DATA_W(16), .BURST_LEN(4), .IDLE_GAP(2), .PAGE_W(4), .PAGE_ID(2)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data), .cmd_err(cmd_err), .busy(busy),
    .AddrValid(AddrValid), .rw(rw), .AddrData(AddrData));

  bus_primary_engine #(.DATA_W(32), .BURST_LEN(8), .IDLE_GAP(1), .PAGE_W(4), .PAGE_ID(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_rw(b_cmd_rw),
    .cmd_addr(b_cmd_addr), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_data(b_wr_data),
    .rd_valid(b_rd_valid), .rd_last(b_rd_last), .rd_data(b_rd_data), .cmd_err(b_cmd_err), .busy(b_busy),
    .AddrValid(b_AddrValid), .rw(b_rw), .AddrData(b_AddrData));

  // Memory-controller model: captures write beats, drives read beats after the turnaround cycle.
  logic        m_en = 1'b0;
  logic [15:0] m_val = '0, m_addr = '0;
  logic [7:0]  m_idx;
  logic [15:0] mem [256];
  int          m_mode = 0, m_beat = 0, drive_viol = 0;

  assign AddrData = m_en ? m_val : 16'hzzzz;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_mode = 0;
      m_en   = 1'b0;
    end else if (AddrValid) begin
      m_addr = AddrData;
      m_beat = 0;
      m_mode = rw ? 2 : 1;
      m_en   = 1'b0;
    end else begin
      case (m_mode)
        1: begin
          if (!rw) begin
            m_idx = m_addr[7:0] + 8'(m_beat);
            mem[m_idx] = AddrData;
            m_beat++;
            if (m_beat == 4) m_mode = 0;
          end else m_mode = 0;
        end
        2: begin
          if (!rw) drive_viol++;
          m_en   = 1'b1;
          m_val  = mem[m_addr[7:0]];
          m_beat = 0;
          m_mode = 3;
        end
        3: begin
          if (!rw) drive_viol++;
          if (m_beat < 4) begin
            m_idx = m_addr[7:0] + 8'(m_beat);
            m_val = mem[m_idx];
            m_beat++;
          end else begin
            m_en   = 1'b0;
            m_mode = 0;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic push_beats(input logic [3:0][15:0] d);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = d[i];
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Returns at the falling edge of the cycle after the accepting edge.
  task automatic issue_cmd(input logic rw_i, input logic [15:0] addr_i);
    int k;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw_i;
    cmd_addr  = addr_i;
    #1;
    k = 0;
    while (!cmd_ready && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (AddrValid !== 1'b0) begin miscompares++; $display("FAIL rst_addrvalid: got %b want 0", AddrValid); end
    vectors++; if (rw !== 1'b1) begin miscompares++; $display("FAIL rst_rw: got %b want 1", rw); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    vectors++; if ({rd_valid, rd_last, cmd_err} !== 3'b000) begin miscompares++; $display("FAIL rst_pulses: got %b want 000", {rd_valid, rd_last, cmd_err}); end
    vectors++; if (rd_data !== 16'h0000) begin miscompares++; $display("FAIL rst_rd_data: got %h want 0000", rd_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    logic [3:0][15:0] exp_w = {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD};
    push_beats(exp_w);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    #1;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL wr_full_ready: got %b want 0", wr_ready); end
    @(negedge clk);
    wr_valid = 1'b0;
    issue_cmd(1'b0, 16'h2000);
    vectors++; if ({AddrValid, rw} !== 2'b10) begin miscompares++; $display("FAIL wr_addr_phase: AddrValid,rw got %b want 10", {AddrValid, rw}); end
    vectors++; if (AddrData !== 16'h2000) begin miscompares++; $display("FAIL wr_addr_value: got %h want 2000", AddrData); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      vectors++; if ({AddrValid, rw} !== 2'b00) begin miscompares++; $display("FAIL wr_beat%0d_ctl: AddrValid,rw got %b want 00", b, {AddrValid, rw}); end
      vectors++; if (AddrData !== exp_w[b]) begin miscompares++; $display("FAIL wr_beat%0d_data: got %h want %h", b, AddrData, exp_w[b]); end
    end
    @(negedge clk);
    vectors++; if ({AddrValid, rw} !== 2'b01) begin miscompares++; $display("FAIL wr_release: AddrValid,rw got %b want 01", {AddrValid, rw}); end
  endtask

  task automatic test_read;
    logic [3:0][15:0] exp_r = {16'h9ABC, 16'h5678, 16'h1234, 16'hABCD};
    int n = 0;
    int first = -1;
    int dv0 = drive_viol;
    issue_cmd(1'b1, 16'h2000);
    vectors++; if ({AddrValid, rw} !== 2'b11) begin miscompares++; $display("FAIL rd_addr_phase: AddrValid,rw got %b want 11", {AddrValid, rw}); end
    vectors++; if (AddrData !== 16'h2000) begin miscompares++; $display("FAIL rd_addr_value: got %h want 2000", AddrData); end
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++; if ({AddrValid, rw} !== 2'b01) begin miscompares++; $display("FAIL rd_turn_release: AddrValid,rw got %b want 01", {AddrValid, rw}); end
      end
      if (rd_valid) begin
        if (first < 0) first = c;
        if (n < 4) begin
          vectors++; if (rd_data !== exp_r[n]) begin miscompares++; $display("FAIL rd_beat%0d_data: got %h want %h", n, rd_data, exp_r[n]); end
          vectors++; if (rd_last !== (n == 3)) begin miscompares++; $display("FAIL rd_beat%0d_last: got %b want %b", n, rd_last, (n == 3)); end
        end
        n++;
      end
    end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL rd_beat_count: got %0d want 4", n); end
    vectors++; if (first != 3) begin miscompares++; $display("FAIL rd_latency: first rd_valid %0d cycles after ADDR, want 3", first); end
    vectors++; if (drive_viol != dv0) begin miscompares++; $display("FAIL rd_no_drive: %0d primary-drive cycles in TURN/RDATA, want 0", drive_viol - dv0); end
  endtask

  task automatic test_back_to_back;
    logic [3:0][15:0] exp_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    int wbeats = 0, released = 0, held = 0, n = 0;
    logic saw_addr = 1'b0;
    logic [15:0] addr_seen = '0;
    logic rw_seen = 1'b0;
    push_beats(exp_b);
    issue_cmd(1'b0, 16'h2010);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 16'h2010;
    for (int c = 0; c < 20 && !saw_addr; c++) begin
      @(negedge clk);
      if (AddrValid) begin
        saw_addr  = 1'b1;
        addr_seen = AddrData;
        rw_seen   = rw;
        cmd_valid = 1'b0;
      end else if (!rw) begin
        wbeats++;
        released = 0;
        if (cmd_ready) held++;
      end else released++;
    end
    cmd_valid = 1'b0;
    vectors++; if (saw_addr !== 1'b1) begin miscompares++; $display("FAIL b2b_second_addr: seen %b want 1", saw_addr); end
    vectors++; if (wbeats != 4) begin miscompares++; $display("FAIL b2b_write_beats: got %0d want 4", wbeats); end
    vectors++; if (released != 2) begin miscompares++; $display("FAIL b2b_gap: got %0d released cycles want 2", released); end
    vectors++; if (held != 0) begin miscompares++; $display("FAIL b2b_held_off: cmd_ready high in %0d busy cycles want 0", held); end
    vectors++; if ({rw_seen, addr_seen} !== {1'b1, 16'h2010}) begin miscompares++; $display("FAIL b2b_read_addr: rw,addr got %b,%h want 1,2010", rw_seen, addr_seen); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        if (n < 4) begin
          vectors++; if (rd_data !== exp_b[n]) begin miscompares++; $display("FAIL b2b_rd%0d: got %h want %h", n, rd_data, exp_b[n]); end
        end
        n++;
      end
    end
    vectors++; if (n != 4) begin miscompares++; $display("FAIL b2b_rd_count: got %0d want 4", n); end
  endtask

  task automatic test_addr_check;
    logic [3:0][15:0] exp_a = {16'hAAA3, 16'hAAA2, 16'hAAA1, 16'hAAA0};
    push_beats(exp_a);
    issue_cmd(1'b0, 16'h5000);
`ifdef ADDR_CHECK_EN
    vectors++; if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL chk_err_pulse: got %b want 1", cmd_err); end
    vectors++; if ({AddrValid, busy} !== 2'b00) begin miscompares++; $display("FAIL chk_no_bus: AddrValid,busy got %b want 00", {AddrValid, busy}); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL chk_buffer_cleared: wr_ready got %b want 1", wr_ready); end
    begin
      int av = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (AddrValid) av++;
        if (c == 0) begin
          vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL chk_err_one_cycle: got %b want 0", cmd_err); end
        end
      end
      vectors++; if (av != 0) begin miscompares++; $display("FAIL chk_addrvalid_quiet: %0d strobes want 0", av); end
    end
`else
    vectors++; if ({AddrValid, AddrData} !== {1'b1, 16'h5000}) begin miscompares++; $display("FAIL nochk_addr: AddrValid,AddrData got %b,%h want 1,5000", AddrValid, AddrData); end
    vectors++; if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL nochk_err: got %b want 0", cmd_err); end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      vectors++; if ({rw, AddrData} !== {1'b0, exp_a[b]}) begin miscompares++; $display("FAIL nochk_beat%0d: rw,data got %b,%h want 0,%h", b, rw, AddrData, exp_a[b]); end
    end
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic test_burst8;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      b_wr_valid = 1'b1;
      b_wr_data  = 32'h1000_0000 + 32'(i);
    end
    @(negedge clk);
    b_wr_valid = 1'b0;
    b_cmd_valid = 1'b1;
    b_cmd_rw    = 1'b0;
    b_cmd_addr  = 32'h2000_0040;
    #1;
    vectors++; if (b_cmd_ready !== 1'b0) begin miscompares++; $display("FAIL b8_ready_7beats: got %b want 0", b_cmd_ready); end
    repeat (2) @(negedge clk);
    vectors++; if ({b_busy, b_AddrValid, b_cmd_ready} !== 3'b000) begin miscompares++; $display("FAIL b8_held: busy,AddrValid,ready got %b want 000", {b_busy, b_AddrValid, b_cmd_ready}); end
    b_wr_valid = 1'b1;
    b_wr_data  = 32'h1000_0007;
    @(negedge clk);
    b_wr_valid = 1'b0;
    #1;
    vectors++; if (b_cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b8_ready_8beats: got %b want 1", b_cmd_ready); end
    @(negedge clk);
    b_cmd_valid = 1'b0;
    vectors++; if ({b_AddrValid, b_AddrData} !== {1'b1, 32'h2000_0040}) begin miscompares++; $display("FAIL b8_addr: AddrValid,AddrData got %b,%h want 1,20000040", b_AddrValid, b_AddrData); end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      vectors++; if ({b_AddrValid, b_rw, b_AddrData} !== {2'b00, 32'h1000_0000 + 32'(b)}) begin miscompares++; $display("FAIL b8_beat%0d: AddrValid,rw,data got %b%b,%h want 00,%h", b, b_AddrValid, b_rw, b_AddrData, 32'h1000_0000 + 32'(b)); end
    end
    @(negedge clk);
    vectors++; if (b_rw !== 1'b1) begin miscompares++; $display("FAIL b8_release: rw got %b want 1", b_rw); end
  endtask

  task automatic test_reset_mid_burst;
    push_beats({16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A});
    issue_cmd(1'b0, 16'h2020);
    repeat (2) @(negedge clk);
    vectors++; if ({busy, rw} !== 2'b10) begin miscompares++; $display("FAIL mid_in_wdata: busy,rw got %b want 10", {busy, rw}); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({AddrValid, rw} !== 2'b01) begin miscompares++; $display("FAIL mid_bus_released: AddrValid,rw got %b want 01", {AddrValid, rw}); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL mid_wr_ready: got %b want 1", wr_ready); end
    vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL mid_cmd_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({busy, AddrValid, wr_ready} !== 3'b001) begin miscompares++; $display("FAIL mid_after_release: busy,AddrValid,wr_ready got %b want 001", {busy, AddrValid, wr_ready}); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_back_to_back;
    test_addr_check;
    test_burst8;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
